// File: rtl/gmac_pkg.sv
// Shared types and constants for the GMAC receive frame controller.
package gmac_pkg;

    localparam int LEN_W = 14;

    localparam logic [LEN_W-1:0] MIN_FRAME_LEN = LEN_W'(64);
    localparam logic [LEN_W-1:0] DA_LEN        = LEN_W'(6);
    localparam logic [47:0]      BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;

    // Write-side frame state.
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_RECV = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

    // Outcome of the end-of-frame decision; DEC_NONE when no frame closes this cycle.
    typedef enum logic [2:0] {
        DEC_NONE = 3'd0,
        DEC_OK   = 3'd1,
        DEC_ERR  = 3'd2,
        DEC_LEN  = 3'd3,
        DEC_FILT = 3'd4,
        DEC_FULL = 3'd5
    } rx_dec_e;

    // Byte idx of a MAC address in wire order (byte 0 is [47:40]).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// Frame byte store: simple dual-port, single clock, registered read.
module rx_frame_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write port and registered read port; read data holds when rd_en is low.
    // NOTE: the array and its read register have no reset: the pointers in the
    // controller decide which entries are meaningful, and a reset on a RAM
    // would stop it mapping onto block memory.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples values
    // from before the edge; blocking (=) is reserved for always_comb.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: buffers frames, filters on DA and length, commits
// or rewinds at end of frame, streams committed frames to the reader.
module rx_frame_ctrl
    import gmac_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int STAT_W = 32
) (
    input  logic              gmii_rx_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              in_good,
    input  logic              in_bad,
    input  logic [47:0]       cfg_mac_addr,
    input  logic              cfg_promisc,
    input  logic              cfg_accept_mcast,
    input  logic [LEN_W-1:0]  cfg_max_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic [STAT_W-1:0] stat_rx_ok,
    output logic [STAT_W-1:0] stat_rx_err,
    output logic [STAT_W-1:0] stat_rx_filt,
    output logic [STAT_W-1:0] stat_rx_len,
    output logic [STAT_W-1:0] stat_rx_full
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Write side state
    wr_state_e        state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    cm_ptr_q, cm_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             da_match_q, da_match_d;
    logic             da_bcast_q, da_bcast_d;
    logic             da_mcast_q, da_mcast_d;
    logic             full_q, full_d;

    // Read side state
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ram_vld_q, ram_vld_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             in_ready_q, in_ready_d;

    logic [STAT_W-1:0] stat_ok_q, stat_ok_d;
    logic [STAT_W-1:0] stat_err_q, stat_err_d;
    logic [STAT_W-1:0] stat_filt_q, stat_filt_d;
    logic [STAT_W-1:0] stat_len_q, stat_len_d;
    logic [STAT_W-1:0] stat_full_q, stat_full_d;

    logic [PW-1:0]    used;
    logic             buf_full;
    logic [LEN_W-1:0] byte_idx;
    logic [LEN_W-1:0] cur_len;
    logic             addr_ok;
    rx_dec_e          dec;

    logic             mem_we;
    logic [8:0]       mem_wdata;
    logic             rd_en;
    logic [8:0]       rd_data;
    logic             readable;
    logic             out_load;

    // Occupancy counts bytes from the reader up to the speculative write pointer.
    assign used     = wr_ptr_q - rd_ptr_q;
    assign buf_full = (used == DEPTH);

    // Write FSM: store bytes, track length and DA, decide commit or rewind on the last beat.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        len_d      = len_q;
        da_match_d = da_match_q;
        da_bcast_d = da_bcast_q;
        da_mcast_d = da_mcast_q;
        full_d     = full_q;
        mem_we     = 1'b0;
        mem_wdata  = {in_last, in_data};
        dec        = DEC_NONE;
        byte_idx   = (state_q == WR_IDLE) ? '0 : len_q;
        cur_len    = (state_q == WR_IDLE) ? LEN_W'(1) : ((&len_q) ? len_q : len_q + 1'b1);
        addr_ok    = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                WR_IDLE, WR_RECV: begin
                    len_d = cur_len;
                    if (byte_idx == '0) begin
                        da_match_d = (in_data == mac_byte(cfg_mac_addr, 3'd0));
                        da_bcast_d = (in_data == mac_byte(BCAST_ADDR, 3'd0));
                        da_mcast_d = in_data[0];
                    end else if (byte_idx < DA_LEN) begin
                        da_match_d = da_match_q & (in_data == mac_byte(cfg_mac_addr, byte_idx[2:0]));
                        da_bcast_d = da_bcast_q & (in_data == mac_byte(BCAST_ADDR, byte_idx[2:0]));
                    end
                    addr_ok = cfg_promisc | da_match_d | da_bcast_d | (da_mcast_d & cfg_accept_mcast);

                    if (in_last) begin
                        if (buf_full || full_q) begin
                            dec = DEC_FULL;
                        end else if (in_bad || !in_good) begin
                            dec = DEC_ERR;
                        end else if ((cur_len < MIN_FRAME_LEN) || (cur_len > cfg_max_len)) begin
                            dec = DEC_LEN;
                        end else if (!addr_ok) begin
                            dec = DEC_FILT;
                        end else begin
                            dec = DEC_OK;
                        end
                    end else if (buf_full) begin
                        full_d  = 1'b1;
                        state_d = WR_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = WR_RECV;
                    end
                end
                WR_DROP: begin
                    if (in_last) begin
                        dec = full_q ? DEC_FULL : DEC_ERR;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end

        // Closing a frame: commit writes the tagged last byte, anything else rewinds.
        if (dec == DEC_OK) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cm_ptr_d = wr_ptr_q + 1'b1;
        end else if (dec != DEC_NONE) begin
            wr_ptr_d = cm_ptr_q;
        end
        if (dec != DEC_NONE) begin
            state_d = WR_IDLE;
            full_d  = 1'b0;
        end
    end

    // Statistics: one saturating increment per closed frame.
    always_comb begin
        stat_ok_d   = stat_ok_q;
        stat_err_d  = stat_err_q;
        stat_filt_d = stat_filt_q;
        stat_len_d  = stat_len_q;
        stat_full_d = stat_full_q;
        unique case (dec)
            DEC_OK:   stat_ok_d   = sat_inc(stat_ok_q);
            DEC_ERR:  stat_err_d  = sat_inc(stat_err_q);
            DEC_LEN:  stat_len_d  = sat_inc(stat_len_q);
            DEC_FILT: stat_filt_d = sat_inc(stat_filt_q);
            DEC_FULL: stat_full_d = sat_inc(stat_full_q);
            default:  ;
        endcase
    end

    // Read side: RAM output acts as a one-entry stage in front of the output register.
    always_comb begin
        readable    = (rd_ptr_q != cm_ptr_q);
        out_load    = ram_vld_q && (!out_valid_q || out_ready);
        rd_en       = readable && (!ram_vld_q || out_load);
        rd_ptr_d    = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_vld_d   = rd_en | (ram_vld_q & ~out_load);
        out_valid_d = out_load | (out_valid_q & ~out_ready);
        out_data_d  = out_load ? rd_data[7:0] : out_data_q;
        out_last_d  = out_load ? rd_data[8] : out_last_q;
        in_ready_d  = 1'b1;
    end

    // State registers; reset discards all buffered frames and statistics.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state_q     <= WR_IDLE;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            len_q       <= '0;
            da_match_q  <= 1'b0;
            da_bcast_q  <= 1'b0;
            da_mcast_q  <= 1'b0;
            full_q      <= 1'b0;
            rd_ptr_q    <= '0;
            ram_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            stat_ok_q   <= '0;
            stat_err_q  <= '0;
            stat_filt_q <= '0;
            stat_len_q  <= '0;
            stat_full_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            len_q       <= len_d;
            da_match_q  <= da_match_d;
            da_bcast_q  <= da_bcast_d;
            da_mcast_q  <= da_mcast_d;
            full_q      <= full_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_vld_q   <= ram_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            stat_ok_q   <= stat_ok_d;
            stat_err_q  <= stat_err_d;
            stat_filt_q <= stat_filt_d;
            stat_len_q  <= stat_len_d;
            stat_full_q <= stat_full_d;
        end
    end

    rx_frame_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (9)
    ) u_ram (
        .clk     (gmii_rx_clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (mem_wdata),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign stat_rx_ok   = stat_ok_q;
    assign stat_rx_err  = stat_err_q;
    assign stat_rx_filt = stat_filt_q;
    assign stat_rx_len  = stat_len_q;
    assign stat_rx_full = stat_full_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frame table, buffer-full and reset
// sequences, and randomized frames against a frame-level reference model.
module tb_rx_frame_ctrl;

    localparam int ADDR_W = 8;
    localparam int STAT_W = 32;

    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] OTHER = 48'h02_11_22_33_44_56;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

    typedef enum int {O_OK = 0, O_ERR = 1, O_FILT = 2, O_LEN = 3, O_FULL = 4} outcome_e;

    typedef struct {
        int          len;
        logic [47:0] da;
        bit          good;
        bit          bad;
        bit          promisc;
        bit          acc_mcast;
        int          max_len;
        outcome_e    exp;
    } vec_t;

    logic              gmii_rx_clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              in_good;
    logic              in_bad;
    logic [47:0]       cfg_mac_addr;
    logic              cfg_promisc;
    logic              cfg_accept_mcast;
    logic [13:0]       cfg_max_len;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [STAT_W-1:0] stat_rx_ok;
    logic [STAT_W-1:0] stat_rx_err;
    logic [STAT_W-1:0] stat_rx_filt;
    logic [STAT_W-1:0] stat_rx_len;
    logic [STAT_W-1:0] stat_rx_full;

    int         errors = 0;
    int         checks = 0;
    int         exp_stat[5];
    int         rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
    logic [8:0] exp_q[$];       // {last, data} of committed bytes not yet read
    logic [7:0] frm[$];         // frame under construction

    rx_frame_ctrl #(
        .ADDR_W (ADDR_W),
        .STAT_W (STAT_W)
    ) dut (
        .gmii_rx_clk      (gmii_rx_clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .in_good          (in_good),
        .in_bad           (in_bad),
        .cfg_mac_addr     (cfg_mac_addr),
        .cfg_promisc      (cfg_promisc),
        .cfg_accept_mcast (cfg_accept_mcast),
        .cfg_max_len      (cfg_max_len),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .stat_rx_ok       (stat_rx_ok),
        .stat_rx_err      (stat_rx_err),
        .stat_rx_filt     (stat_rx_filt),
        .stat_rx_len      (stat_rx_len),
        .stat_rx_full     (stat_rx_full)
    );

    always #5 gmii_rx_clk = ~gmii_rx_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: what should become of a complete frame with status.
    function automatic outcome_e predict(input int len, input logic [47:0] da, input bit good,
                                         input bit bad, input bit promisc, input bit acc,
                                         input int max_len);
        if (bad || !good) return O_ERR;
        if (len < 64 || len > max_len) return O_LEN;
        if (promisc || da == MAC || da == BCAST || (da[40] && acc)) return O_OK;
        return O_FILT;
    endfunction

    function automatic vec_t mk(input int len, input logic [47:0] da, input bit good, input bit bad,
                                input bit promisc, input bit acc, input int max_len,
                                input outcome_e exp);
        vec_t v;
        v.len = len; v.da = da; v.good = good; v.bad = bad;
        v.promisc = promisc; v.acc_mcast = acc; v.max_len = max_len; v.exp = exp;
        return v;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int len);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) frm.push_back(da[47 - 8*i -: 8]);
            else       frm.push_back(8'($urandom));
        end
    endtask

    task automatic expect_outcome(input outcome_e o);
        exp_stat[o]++;
        if (o == O_OK) begin
            for (int i = 0; i < frm.size(); i++) begin
                exp_q.push_back({1'(i == frm.size() - 1), frm[i]});
            end
        end
    endtask

    // Drive frm; with gaps set, idle beats and status noise on non-last beats are mixed in.
    task automatic send_frame(input bit good, input bit bad, input bit gaps);
        int n;
        n = frm.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0; in_last = 1'b0;
                in_good = 1'($urandom); in_bad = 1'($urandom);
                @(negedge gmii_rx_clk);
            end
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == n - 1);
            if (i == n - 1) begin
                in_good = good; in_bad = bad;
            end else begin
                in_good = gaps ? 1'($urandom) : 1'b0;
                in_bad  = gaps ? 1'($urandom) : 1'b0;
            end
            @(negedge gmii_rx_clk);
        end
        in_valid = 1'b0; in_last = 1'b0; in_good = 1'b0; in_bad = 1'b0;
    endtask

    task automatic set_cfg(input bit promisc, input bit acc, input int max_len);
        cfg_promisc      = promisc;
        cfg_accept_mcast = acc;
        cfg_max_len      = 14'(max_len);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge gmii_rx_clk);
            c++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (4) @(negedge gmii_rx_clk);
    endtask

    task automatic wait_space(input int len);
        int c;
        c = 0;
        while ((exp_q.size() + len > 200) && c < 5000) begin
            @(negedge gmii_rx_clk);
            c++;
        end
        check("space_wait_timeout", (c >= 5000), 0);
    endtask

    task automatic check_stats();
        check("stat_rx_ok",   stat_rx_ok,   exp_stat[O_OK]);
        check("stat_rx_err",  stat_rx_err,  exp_stat[O_ERR]);
        check("stat_rx_filt", stat_rx_filt, exp_stat[O_FILT]);
        check("stat_rx_len",  stat_rx_len,  exp_stat[O_LEN]);
        check("stat_rx_full", stat_rx_full, exp_stat[O_FULL]);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_last",  out_last,  0);
        check("rst_stat_ok",   stat_rx_ok,   0);
        check("rst_stat_err",  stat_rx_err,  0);
        check("rst_stat_filt", stat_rx_filt, 0);
        check("rst_stat_len",  stat_rx_len,  0);
        check("rst_stat_full", stat_rx_full, 0);
    endtask

    // Reader: sets out_ready per mode, checks every accepted byte and output stability under stall.
    initial begin : reader
        logic       hold_v;
        logic [8:0] hold_d;
        logic [8:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge gmii_rx_clk);
            if (hold_v && !rst) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_out_bits", {out_last, out_data}, hold_d);
            end
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom);
            endcase
            hold_v = out_valid && !out_ready && !rst;
            hold_d = {out_last, out_data};
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("extra_out_byte", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", {out_last, out_data}, e);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t     vecs[$];
        outcome_e o;
        int       len, dsel, ssel, max_len;
        bit       good, bad, promisc, acc;
        logic [47:0] da;

        foreach (exp_stat[i]) exp_stat[i] = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_good = 1'b0; in_bad = 1'b0;
        out_ready = 1'b0;
        cfg_mac_addr = MAC;
        set_cfg(0, 0, 1518);

        // Reset state
        repeat (3) @(negedge gmii_rx_clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge gmii_rx_clk);
        check("in_ready_after_reset", in_ready, 1);

        // Directed frame table
        vecs.push_back(mk(64,  MAC,   1, 0, 0, 0, 1518, O_OK));
        vecs.push_back(mk(64,  MAC,   0, 1, 0, 0, 1518, O_ERR));
        vecs.push_back(mk(64,  MAC,   0, 0, 0, 0, 1518, O_ERR));
        vecs.push_back(mk(64,  MAC,   1, 1, 0, 0, 1518, O_ERR));
        vecs.push_back(mk(80,  OTHER, 1, 0, 0, 0, 1518, O_FILT));
        vecs.push_back(mk(80,  BCAST, 1, 0, 0, 0, 1518, O_OK));
        vecs.push_back(mk(80,  MCAST, 1, 0, 0, 0, 1518, O_FILT));
        vecs.push_back(mk(80,  OTHER, 1, 0, 1, 0, 1518, O_OK));
        vecs.push_back(mk(80,  BCAST, 1, 0, 1, 0, 1518, O_OK));
        vecs.push_back(mk(80,  MCAST, 1, 0, 1, 0, 1518, O_OK));
        vecs.push_back(mk(80,  MCAST, 1, 0, 0, 1, 1518, O_OK));
        vecs.push_back(mk(63,  MAC,   1, 0, 0, 0, 1518, O_LEN));
        vecs.push_back(mk(200, MAC,   1, 0, 0, 0, 200,  O_OK));
        vecs.push_back(mk(201, MAC,   1, 0, 0, 0, 200,  O_LEN));
        vecs.push_back(mk(63,  MAC,   0, 1, 0, 0, 1518, O_ERR));
        vecs.push_back(mk(63,  OTHER, 1, 0, 0, 0, 1518, O_LEN));
        vecs.push_back(mk(3,   OTHER, 1, 0, 0, 0, 1518, O_LEN));
        vecs.push_back(mk(1,   MAC,   1, 0, 0, 0, 1518, O_LEN));
        vecs.push_back(mk(65,  MAC,   1, 0, 0, 0, 64,   O_LEN));
        vecs.push_back(mk(64,  MAC,   1, 0, 0, 0, 64,   O_OK));

        rdy_mode = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            set_cfg(vecs[i].promisc, vecs[i].acc_mcast, vecs[i].max_len);
            build_frame(vecs[i].da, vecs[i].len);
            expect_outcome(vecs[i].exp);
            send_frame(vecs[i].good, vecs[i].bad, 0);
            wait_drain(600);
            check_stats();
        end

        // Buffer fills while the reader is stalled: second frame dropped, first intact.
        set_cfg(0, 0, 1518);
        rdy_mode = 0;
        build_frame(MAC, 200);
        expect_outcome(O_OK);
        send_frame(1, 0, 0);
        build_frame(MAC, 100);
        exp_stat[O_FULL]++;
        send_frame(1, 0, 0);
        repeat (4) @(negedge gmii_rx_clk);
        check_stats();
        check("full_out_valid_held", out_valid, 1);
        check("full_first_byte", {out_last, out_data}, exp_q[0]);
        rdy_mode = 1;
        wait_drain(1000);
        repeat (10) @(negedge gmii_rx_clk);
        check_stats();

        // Randomized frames, back-to-back or gapped, random reader backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            dsel = $urandom_range(0, 3);
            da = (dsel == 0) ? MAC : (dsel == 1) ? OTHER : (dsel == 2) ? BCAST : MCAST;
            ssel = $urandom_range(0, 9);
            len = (ssel == 0) ? $urandom_range(1, 8) :
                  (ssel < 3)  ? $urandom_range(55, 70) : $urandom_range(60, 130);
            max_len = $urandom_range(100, 140);
            promisc = ($urandom_range(0, 3) == 0);
            acc     = 1'($urandom);
            ssel = $urandom_range(0, 5);
            if (ssel == 0)      begin bad = 1'b1; good = 1'($urandom); end
            else if (ssel == 1) begin bad = 1'b0; good = 1'b0; end
            else                begin bad = 1'b0; good = 1'b1; end
            wait_space(len);
            set_cfg(promisc, acc, max_len);
            build_frame(da, len);
            o = predict(len, da, good, bad, promisc, acc, max_len);
            expect_outcome(o);
            send_frame(good, bad, 1);
            repeat ($urandom_range(0, 2)) @(negedge gmii_rx_clk);
        end
        wait_drain(4000);
        check_stats();

        // Good frame, then reset in the middle of the next frame.
        set_cfg(0, 0, 1518);
        build_frame(MAC, 100);
        expect_outcome(O_OK);
        send_frame(1, 0, 0);
        build_frame(MAC, 80);
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_data = frm[i]; in_last = 1'b0;
            @(negedge gmii_rx_clk);
        end
        in_valid = 1'b0;
        wait_drain(2000);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge gmii_rx_clk);
        check_reset_outputs();
        rst = 1'b0;
        foreach (exp_stat[i]) exp_stat[i] = 0;
        rdy_mode = 1;
        repeat (20) @(negedge gmii_rx_clk);
        check("post_reset_no_residual", out_valid, 0);
        check_stats();
        build_frame(MAC, 70);
        expect_outcome(O_OK);
        send_frame(1, 0, 0);
        wait_drain(600);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
